fetch_aligner: RTL and testbench

FETCH_ALIGNER -- requirements
Module: fetch_aligner

---
 rtl/fetch_aligner.sv | 130 +++++++++++++
 tb/tb_fetch_aligner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// fetch_aligner: turns a stream of 32-bit memory words into aligned RV32C/RV32I
// instructions. Keeps up to three 16-bit halfwords, issues one word fetch at a
// time, and handles redirects (Flush) including dropping stale responses.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req, mem_addr   one-cycle fetch request for the word at mem_addr
//   mem_valid, mem_rdata response for the oldest outstanding request
//   Stall               downstream hold, blocks consumption
//   Flush, redirect_PC_i redirect to a new PC (bit 0 ignored)
//   valid_o, instr_o, PC_o, compress_o  current instruction at buffer head
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] redirect_PC_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic        compress_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HW   = 16;
  localparam int unsigned BUFW = 48;
  localparam int unsigned CW   = 2;

  // IDLE: nothing outstanding; WAIT: response will be used; DROP: response is stale
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t            state_q, state_n;
  logic [BUFW-1:0]   hbuf_q, hbuf_n;
  logic [CW-1:0]     hcnt_q, hcnt_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic [XLEN-1:0]   fetch_q, fetch_n;
  logic              drop_low_q, drop_low_n;
  logic              issue;

  logic              consume;
  logic              fill;
  logic              resp_pending;
  logic [CW-1:0]     cons_n;
  logic [CW-1:0]     fill_n;
  logic [CW-1:0]     hcnt_keep;
  logic [XLEN-1:0]   fill_data;
  logic [BUFW-1:0]   shifted;
  logic [BUFW-1:0]   keep_mask;
  logic [BUFW-1:0]   fill_bits;

  // Head-of-buffer decode
  assign compress_o = (hbuf_q[1:0] != 2'b11);
  assign valid_o    = ((hcnt_q >= 2'd1) && compress_o) || (hcnt_q >= 2'd2);
  assign instr_o    = compress_o ? {16'h0000, hbuf_q[15:0]} : hbuf_q[31:0];
  assign PC_o       = pc_q;

  // Next-state: consume, fill, redirect and fetch issue
  always_comb begin
    state_n      = state_q;
    hbuf_n       = hbuf_q;
    hcnt_n       = hcnt_q;
    pc_n         = pc_q;
    fetch_n      = fetch_q;
    drop_low_n   = drop_low_q;
    issue        = 1'b0;

    consume      = valid_o && !Stall && !Flush;
    fill         = (state_q == S_WAIT) && mem_valid && !Flush;
    resp_pending = (state_q != S_IDLE) && !mem_valid;
    cons_n       = consume ? (compress_o ? 2'd1 : 2'd2) : 2'd0;
    fill_n       = fill ? (drop_low_q ? 2'd1 : 2'd2) : 2'd0;
    hcnt_keep    = hcnt_q - cons_n;
    fill_data    = drop_low_q ? {16'h0000, mem_rdata[31:16]} : mem_rdata;

    // Survivors shift down; new halfwords land directly above them
    shifted      = hbuf_q >> (HW * 32'(cons_n));
    keep_mask    = (BUFW'(1) << (HW * 32'(hcnt_keep))) - BUFW'(1);
    fill_bits    = fill ? (BUFW'(fill_data) << (HW * 32'(hcnt_keep))) : '0;

    if (Flush) begin
      hcnt_n     = '0;
      pc_n       = redirect_PC_i & ~32'd1;
      fetch_n    = redirect_PC_i & ~32'd3;
      drop_low_n = redirect_PC_i[1];
      state_n    = resp_pending ? S_DROP : S_IDLE;
    end else begin
      hbuf_n     = (shifted & keep_mask) | fill_bits;
      hcnt_n     = hcnt_keep + fill_n;
      if (consume) pc_n = pc_q + (compress_o ? 32'd2 : 32'd4);
      if (fill) drop_low_n = 1'b0;
      state_n    = resp_pending ? state_q : S_IDLE;
      // Request only when the buffer can absorb a full word afterwards
      if (!resp_pending && (hcnt_n <= 2'd1)) begin
        issue    = 1'b1;
        state_n  = S_WAIT;
        fetch_n  = fetch_q + 32'd4;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hbuf_q     <= '0;
      hcnt_q     <= '0;
      pc_q       <= RESET_PC;
      fetch_q    <= RESET_PC & ~32'd3;
      drop_low_q <= RESET_PC[1];
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC & ~32'd3;
    end else begin
      state_q    <= state_n;
      hbuf_q     <= hbuf_n;
      hcnt_q     <= hcnt_n;
      pc_q       <= pc_n;
      fetch_q    <= fetch_n;
      drop_low_q <= drop_low_n;
      mem_req    <= issue;
      if (issue) mem_addr <= fetch_q;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: drives fetch_aligner with a latency-randomized word memory
// and compares the instruction stream to a PC-walking reference model.
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] redirect_PC_i = '0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] PC_o;
  logic        compress_o;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .Stall(Stall), .Flush(Flush),
    .redirect_PC_i(redirect_PC_i), .valid_o(valid_o), .instr_o(instr_o),
    .PC_o(PC_o), .compress_o(compress_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sparse word memory, lazily filled with random words
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  exp_t        dq[$];
  logic [31:0] pend_addr[$];
  int          pend_cnt[$];
  logic [31:0] m_pc;
  logic [31:0] exp_fetch;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          expect_req = 1'b0;
  bit          spurious_en = 1'b0;
  int          idle = 0;

  // One cycle at a negedge: check outputs, advance model, run memory, drive inputs
  task automatic cycle(input bit stall, input bit flush, input logic [31:0] rpc);
    logic [15:0] h0;
    logic        comp;
    logic [31:0] ins;
    exp_t        e;
    h0   = half_at(m_pc);
    comp = (h0[1:0] != 2'b11);
    ins  = comp ? {16'h0000, h0} : {half_at(m_pc + 32'd2), h0};

    if (expect_req) begin
      check("req_after_rst", 32'(mem_req), 32'd1);
      expect_req = 1'b0;
    end
    if (mem_req) begin
      check("mem_addr", mem_addr, exp_fetch);
      check("one_outstanding", 32'(pend_addr.size()), 32'd0);
      exp_fetch += 32'd4;
      pend_addr.push_back(mem_addr);
      pend_cnt.push_back(int'($urandom_range(lat_max, lat_min)));
    end
    if (valid_o) begin
      check("pc", PC_o, m_pc);
      check("instr", instr_o, ins);
      check("compress", 32'(compress_o), 32'(comp));
    end
    if (valid_o && !stall && !flush) begin
      if (dq.size() > 0) begin
        e = dq.pop_front();
        check("dir_pc", PC_o, e.pc);
        check("dir_instr", instr_o, e.instr);
        check("dir_compress", 32'(compress_o), 32'(e.comp));
      end
      m_pc += comp ? 32'd2 : 32'd4;
      idle = 0;
    end else if (!stall) begin
      idle++;
    end
    if (idle > 40) begin
      check("progress", 32'd1, 32'd0);
      idle = 0;
    end

    mem_valid = 1'b0;
    if (pend_addr.size() > 0) begin
      if (pend_cnt[0] == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_cnt.pop_front());
      end else begin
        pend_cnt[0] = pend_cnt[0] - 1;
      end
    end else if (spurious_en && ($urandom_range(19, 0) == 0)) begin
      mem_valid = 1'b1;
      mem_rdata = $urandom;
    end

    if (flush) begin
      m_pc      = rpc & ~32'd1;
      exp_fetch = rpc & ~32'd3;
      idle      = 0;
    end
    Stall         = stall;
    Flush         = flush;
    redirect_PC_i = rpc;
    @(negedge clk);
  endtask

  // Reset; any pending response is delivered during reset and must be ignored
  task automatic do_reset();
    rst   = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    mem_valid = (pend_addr.size() > 0);
    mem_rdata = $urandom;
    pend_addr.delete();
    pend_cnt.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      mem_valid = 1'b0;
    end
    rst        = 1'b0;
    m_pc       = RESET_PC;
    exp_fetch  = RESET_PC & ~32'd3;
    expect_req = 1'b1;
    idle       = 0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0);
  endtask

  task automatic end_directed(input string tag);
    check(tag, 32'(dq.size()), 32'd0);
    dq.delete();
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    int          stall_left;
    bit          st;
    bit          fl;
    logic [31:0] rpc;

    // Single 32-bit instruction from reset
    mem.delete();
    mem[32'h0] = 32'h00A0_0093;
    dq.push_back('{32'h0, 32'h00A0_0093, 1'b0});
    do_reset();
    run(12);
    end_directed("dq_t1");

    // Two compressed instructions in one word
    mem.delete();
    mem[32'h0] = 32'h4501_4505;
    dq.push_back('{32'h0, 32'h0000_4505, 1'b1});
    dq.push_back('{32'h2, 32'h0000_4501, 1'b1});
    do_reset();
    run(12);
    end_directed("dq_t2");

    // 32-bit instruction straddling two words, with slow memory
    mem.delete();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h4501_00A0;
    dq.push_back('{32'h0, 32'h0000_4505, 1'b1});
    dq.push_back('{32'h2, 32'h00A0_0093, 1'b0});
    dq.push_back('{32'h6, 32'h0000_4501, 1'b1});
    lat_min = 3; lat_max = 3;
    do_reset();
    run(20);
    end_directed("dq_t3");

    // Flush to 0x102 while the first request is outstanding
    mem.delete();
    mem[32'h100] = 32'h4501_1234;
    dq.push_back('{32'h102, 32'h0000_4501, 1'b1});
    do_reset();
    cycle(1'b0, 1'b1, 32'h0000_0102);
    run(15);
    end_directed("dq_t4");

    // Stall held for 5 cycles while an instruction is valid
    mem.delete();
    mem[32'h0] = 32'h4501_4505;
    lat_min = 0; lat_max = 0;
    do_reset();
    for (int i = 0; i < 20 && !valid_o; i++) cycle(1'b0, 1'b0, 32'd0);
    check("stall_start_valid", 32'(valid_o), 32'd1);
    held_pc    = PC_o;
    held_instr = instr_o;
    repeat (5) cycle(1'b1, 1'b0, 32'd0);
    check("stall_valid", 32'(valid_o), 32'd1);
    check("stall_pc", PC_o, held_pc);
    check("stall_instr", instr_o, held_instr);
    run(10);

    // Reset while a request is outstanding; stale response ignored
    mem.delete();
    mem[32'h0] = 32'h00A0_0093;
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(1'b0, 1'b0, 32'd0);
    dq.push_back('{32'h0, 32'h00A0_0093, 1'b0});
    do_reset();
    run(15);
    end_directed("dq_t6");

    // Randomized traffic: latency, stalls, flushes, resets, spurious responses
    mem.delete();
    lat_min = 0; lat_max = 3;
    spurious_en = 1'b1;
    stall_left = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999, 0) < 4) begin
        do_reset();
      end else begin
        if (stall_left > 0) begin
          st = 1'b1;
          stall_left--;
        end else begin
          st = 1'b0;
          if ($urandom_range(7, 0) == 0) stall_left = int'($urandom_range(6, 1));
        end
        fl = ($urandom_range(99, 0) < 3);
        if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else rpc = $urandom;
        cycle(st, fl, rpc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
